// File: rtl/xadc_pkg.sv
// Shared widths, state type and saturation helper for the XADC sample conditioner.
package xadc_pkg;

   localparam int XADC_RAW_W    = 12;
   localparam int XADC_DATA_W   = 16;
   localparam int AVG_FRAC_BITS = 4;

   typedef enum logic {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } cond_state_t;

   // Clamp a wide scaled product to the 16-bit output range.
   function automatic logic [XADC_DATA_W-1:0] sat_data(input logic [47:0] v);
      if (|v[47:XADC_DATA_W]) begin
         return '1;
      end
      return v[XADC_DATA_W-1:0];
   endfunction

endpackage

// File: rtl/xadc_sample_conditioner_sample_window_ram.sv
// Ring buffer holding the last 2**AVG_LOG2 raw samples plus its write pointer.
// Asynchronous read of the slot about to be overwritten, synchronous write;
// the array has no reset so it maps onto distributed RAM.
module sample_window_ram
   import xadc_pkg::*;
#(
   parameter int AVG_LOG2 = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  wr_en_i,
   input  logic [XADC_RAW_W-1:0] wr_data_i,
   output logic [XADC_RAW_W-1:0] rd_data_o,
   output logic [AVG_LOG2-1:0]   wr_ptr_o
);

   localparam int DEPTH = 2 ** AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] PTR_ONE = 1;

   logic [XADC_RAW_W-1:0] mem_q [DEPTH];
   logic [AVG_LOG2-1:0]   wr_ptr_q;
   logic [AVG_LOG2-1:0]   wr_ptr_d;

   // Pointer advances once per accepted sample and wraps naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (wr_en_i) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Sample storage; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[wr_ptr_q];
   assign wr_ptr_o  = wr_ptr_q;

endmodule

// File: rtl/xadc_sample_conditioner.sv
// XADC sample conditioner: held raw sample, windowed moving average (12.4)
// and scaled reading, each with its own valid pulse.
// Optional min/max tracking is built when XADC_MINMAX_EN is defined.
//
// state  | meaning
// WARMUP | window not yet filled; leaving samples are treated as zero
// RUN    | window full; oldest sample is subtracted on every accept
module xadc_sample_conditioner
   import xadc_pkg::*;
#(
   parameter int AVG_LOG2    = 8,
   parameter int SCALE_MULT  = 1000,
   parameter int SCALE_SHIFT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_valid,
   input  logic [XADC_RAW_W-1:0]  sample_data,
   output logic [XADC_RAW_W-1:0]  xadc_raw,
   output logic [XADC_DATA_W-1:0] xadc_averaged,
   output logic [XADC_DATA_W-1:0] xadc_scaled,
   output logic                   avg_valid,
   output logic                   scaled_valid,
   output logic                   window_full
`ifdef XADC_MINMAX_EN
   ,
   output logic [XADC_RAW_W-1:0]  xadc_min,
   output logic [XADC_RAW_W-1:0]  xadc_max,
   input  logic                   minmax_clear
`endif
);

   localparam int SUM_W = XADC_RAW_W + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] LAST_PTR = '1;
   localparam logic [47:0] MULT = 48'(SCALE_MULT);

   cond_state_t state_q, state_d;

   logic [XADC_RAW_W-1:0]  raw_q, raw_d;
   logic [SUM_W-1:0]       sum_q, sum_d;
   logic [XADC_DATA_W-1:0] avg_q, avg_d;
   logic [XADC_DATA_W-1:0] scaled_q, scaled_d;
   logic                   v1_q, v1_d;
   logic                   avg_valid_q, avg_valid_d;
   logic                   scaled_valid_q, scaled_valid_d;

   logic [XADC_RAW_W-1:0]  rd_data;
   logic [AVG_LOG2-1:0]    wr_ptr;
   logic [XADC_RAW_W-1:0]  old_sample;
   logic [47:0]            product;

   sample_window_ram #(.AVG_LOG2(AVG_LOG2)) u_window (
      .clk_i     (clk),
      .reset_i   (reset),
      .wr_en_i   (sample_valid),
      .wr_data_i (sample_data),
      .rd_data_o (rd_data),
      .wr_ptr_o  (wr_ptr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WARMUP;
      end else begin
         state_q <= state_d;
      end
   end

   // Write pointer doubles as the fill count: both start at 0 and the first
   // wrap coincides with the window becoming full.
   always_comb begin
      state_d = state_q;
      if (state_q == WARMUP && sample_valid && wr_ptr == LAST_PTR) begin
         state_d = RUN;
      end
   end

   // FSM outputs.
   always_comb begin
      window_full = (state_q == RUN);
   end

   assign old_sample = (state_q == RUN) ? rd_data : '0;
   assign product    = 48'(avg_q) * MULT;

   // Three-stage pipeline: accumulate, average, scale.
   always_comb begin
      raw_d          = raw_q;
      sum_d          = sum_q;
      avg_d          = avg_q;
      scaled_d       = scaled_q;
      v1_d           = sample_valid;
      avg_valid_d    = v1_q;
      scaled_valid_d = avg_valid_q;
      if (sample_valid) begin
         raw_d = sample_data;
         sum_d = sum_q + SUM_W'(sample_data) - SUM_W'(old_sample);
      end
      if (v1_q) begin
         avg_d = sum_q[SUM_W-1 -: XADC_DATA_W];
      end
      if (avg_valid_q) begin
         scaled_d = sat_data(product >> SCALE_SHIFT);
      end
   end

   // Pipeline registers; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_q          <= '0;
         sum_q          <= '0;
         avg_q          <= '0;
         scaled_q       <= '0;
         v1_q           <= 1'b0;
         avg_valid_q    <= 1'b0;
         scaled_valid_q <= 1'b0;
      end else begin
         raw_q          <= raw_d;
         sum_q          <= sum_d;
         avg_q          <= avg_d;
         scaled_q       <= scaled_d;
         v1_q           <= v1_d;
         avg_valid_q    <= avg_valid_d;
         scaled_valid_q <= scaled_valid_d;
      end
   end

   assign xadc_raw      = raw_q;
   assign xadc_averaged = avg_q;
   assign xadc_scaled   = scaled_q;
   assign avg_valid     = avg_valid_q;
   assign scaled_valid  = scaled_valid_q;

`ifdef XADC_MINMAX_EN
   logic [XADC_RAW_W-1:0] min_q, min_d;
   logic [XADC_RAW_W-1:0] max_q, max_d;

   // A clear coinciding with a sample restarts tracking from that sample.
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (minmax_clear) begin
         if (sample_valid) begin
            min_d = sample_data;
            max_d = sample_data;
         end else begin
            min_d = '1;
            max_d = '0;
         end
      end else if (sample_valid) begin
         if (sample_data < min_q) min_d = sample_data;
         if (sample_data > max_q) max_d = sample_data;
      end
   end

   // Min/max registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign xadc_min = min_q;
   assign xadc_max = max_q;
`endif

endmodule

// File: tb/tb_xadc_sample_conditioner.sv
// Self-checking bench for xadc_sample_conditioner (default parameters).
// Min/max checks are compiled in when XADC_MINMAX_EN is defined.
module tb_xadc_sample_conditioner;

   localparam int TB_LOG2 = 8;
   localparam int WIN     = 2 ** TB_LOG2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [11:0] sample_data = '0;
   logic [11:0] xadc_raw;
   logic [15:0] xadc_averaged;
   logic [15:0] xadc_scaled;
   logic        avg_valid;
   logic        scaled_valid;
   logic        window_full;
`ifdef XADC_MINMAX_EN
   logic [11:0] xadc_min;
   logic [11:0] xadc_max;
   logic        minmax_clear = 1'b0;
`endif

   xadc_sample_conditioner #(.AVG_LOG2(TB_LOG2)) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .xadc_raw      (xadc_raw),
      .xadc_averaged (xadc_averaged),
      .xadc_scaled   (xadc_scaled),
      .avg_valid     (avg_valid),
      .scaled_valid  (scaled_valid),
      .window_full   (window_full)
`ifdef XADC_MINMAX_EN
      ,
      .xadc_min      (xadc_min),
      .xadc_max      (xadc_max),
      .minmax_clear  (minmax_clear)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   typedef struct {
      int avg;
      int scl;
      int cyc;
   } exp_t;

   exp_t avg_sb[$];
   exp_t scl_sb[$];
   int   hist[$];

   bit   mono_en = 0;
   int   prev_avg = 0;
   int   pulse_cnt = 0;

   // Scoreboard consumer: value and latency of every valid pulse.
   always @(negedge clk) begin
      if (avg_valid) begin
         if (avg_sb.size() == 0) begin
            chk("avg_unexpected", avg_valid, 0);
         end else begin
            exp_t e;
            e = avg_sb.pop_front();
            chk("avg_value", xadc_averaged, e.avg);
            chk("avg_latency", cyc, e.cyc + 2);
         end
         if (mono_en) begin
            chk("avg_monotonic", (int'(xadc_averaged) >= prev_avg) ? 1 : 0, 1);
            pulse_cnt++;
         end
         prev_avg = xadc_averaged;
      end
      if (scaled_valid) begin
         if (scl_sb.size() == 0) begin
            chk("scl_unexpected", scaled_valid, 0);
         end else begin
            exp_t e;
            e = scl_sb.pop_front();
            chk("scl_value", xadc_scaled, e.scl);
            chk("scl_latency", cyc, e.cyc + 3);
         end
      end
   end

   // Reference: average is the sum of the last WIN samples (zeros before
   // the window fills) divided by 16, scaled value is avg*1000>>16 clamped.
   task automatic drive(input logic [11:0] d, input bit use_tab = 0,
                        input int tavg = 0, input int tscl = 0);
      longint s;
      longint sc;
      exp_t   e;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = d;
      hist.push_back(int'(d));
      if (hist.size() > WIN) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      e.avg = int'(s >> (TB_LOG2 - 4));
      sc = (longint'(e.avg) * 1000) >> 16;
      e.scl = (sc > 65535) ? 65535 : int'(sc);
      if (use_tab) begin
         e.avg = tavg;
         e.scl = tscl;
      end
      e.cyc = cyc;
      avg_sb.push_back(e);
      scl_sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      sample_valid = 1'b0;
`ifdef XADC_MINMAX_EN
      minmax_clear = 1'b0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sample_valid = 1'b0;
      avg_sb.delete();
      scl_sb.delete();
      hist.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((avg_sb.size() != 0 || scl_sb.size() != 0) && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (avg_sb.size() != 0 || scl_sb.size() != 0)
         chk("drain_timeout", avg_sb.size() + scl_sb.size(), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_raw"}, xadc_raw, 0);
      chk({tag, "_avg"}, xadc_averaged, 0);
      chk({tag, "_scl"}, xadc_scaled, 0);
      chk({tag, "_wf"}, window_full, 0);
      chk({tag, "_avgv"}, avg_valid, 0);
      chk({tag, "_sclv"}, scaled_valid, 0);
   endtask

   typedef struct {
      logic [11:0] data;
      int          avg;
      int          scl;
   } vec_t;

   vec_t vecs[8];

   initial begin
      // Running sum after each entry: 16,48,304,4399,4400,6448,8495,8495.
      vecs[0] = '{12'h010, 16'h0001, 0};
      vecs[1] = '{12'h020, 16'h0003, 0};
      vecs[2] = '{12'h100, 16'h0013, 0};
      vecs[3] = '{12'hFFF, 16'h0112, 4};
      vecs[4] = '{12'h001, 16'h0113, 4};
      vecs[5] = '{12'h800, 16'h0193, 6};
      vecs[6] = '{12'h7FF, 16'h0212, 8};
      vecs[7] = '{12'h000, 16'h0212, 8};

      do_reset();
      @(negedge clk);
      chk_zero("reset");
`ifdef XADC_MINMAX_EN
      chk("reset_min", xadc_min, 12'hFFF);
      chk("reset_max", xadc_max, 0);
`endif

      // Table of distinct samples, each followed by an idle cycle.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].data, 1, vecs[i].avg, vecs[i].scl);
         idle();
         chk("tab_raw", xadc_raw, vecs[i].data);
      end
      drain();

      // Latency of a single strobe.
      do_reset();
      drive(12'h400);
      idle();
      chk("lat_avgv_c1", avg_valid, 0);
      @(negedge clk);
      chk("lat_avgv_c2", avg_valid, 1);
      chk("lat_sclv_c2", scaled_valid, 0);
      @(negedge clk);
      chk("lat_sclv_c3", scaled_valid, 1);
      chk("lat_avgv_c3", avg_valid, 0);
      drain();

      // Warm-up ramp: 16 full-scale samples.
      do_reset();
      for (int i = 0; i < 16; i++) drive(12'hFFF);
      idle();
      drain();
      chk("warm_avg", xadc_averaged, 16'h0FFF);
      chk("warm_wf", window_full, 0);

      // Full window of mid-scale; window_full exactly on the last accept.
      do_reset();
      for (int i = 0; i < WIN - 1; i++) drive(12'h800);
      idle();
      chk("fill_wf_early", window_full, 0);
      drive(12'h800);
      idle();
      chk("fill_wf", window_full, 1);
      drain();
      chk("fill_avg", xadc_averaged, 16'h8000);
      chk("fill_scl", xadc_scaled, 500);

      // Zeros then full-scale back-to-back across the window wrap.
      do_reset();
      mono_en = 1;
      pulse_cnt = 0;
      prev_avg = 0;
      for (int i = 0; i < WIN; i++) drive(12'h000);
      for (int i = 0; i < WIN; i++) drive(12'hFFF);
      idle();
      drain();
      mono_en = 0;
      chk("step_pulses", pulse_cnt, 2 * WIN);
      chk("step_avg", xadc_averaged, 16'hFFF0);
      chk("step_scl", xadc_scaled, 999);
      chk("step_wf", window_full, 1);

      // Reset one cycle after a strobe: nothing may emerge.
      do_reset();
      drive(12'h123);
      do_reset();
      repeat (4) @(negedge clk);
      chk_zero("midrst");

`ifdef XADC_MINMAX_EN
      do_reset();
      drive(12'd100);
      drive(12'd3000);
      drive(12'd50);
      idle();
      chk("mm_min", xadc_min, 50);
      chk("mm_max", xadc_max, 3000);
      @(negedge clk);
      minmax_clear = 1'b1;
      idle();
      chk("mm_clr_min", xadc_min, 12'hFFF);
      chk("mm_clr_max", xadc_max, 0);
      drive(12'd200);
      idle();
      drive(12'd7);
      minmax_clear = 1'b1;
      idle();
      chk("mm_clrs_min", xadc_min, 7);
      chk("mm_clrs_max", xadc_max, 7);
      drain();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
